// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing constants, sync payload type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Coordinate width used for every x/y counter and compare
    localparam int COORD_W = 10;

    // Default 640x480@60 Hz timing, 100 MHz system clock
    localparam int c_DEF_CLK_DIV  = 4;
    localparam int c_DEF_H_ACTIVE = 640;
    localparam int c_DEF_H_FP     = 16;
    localparam int c_DEF_H_SYNC   = 96;
    localparam int c_DEF_H_BP     = 48;
    localparam int c_DEF_V_ACTIVE = 480;
    localparam int c_DEF_V_FP     = 10;
    localparam int c_DEF_V_SYNC   = 2;
    localparam int c_DEF_V_BP     = 33;
    localparam int c_DEF_PIPE_LAT = 2;

    // Sync/enable triple carried down the renderer-matching delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } vga_sync_t;

    // Blanked value: both syncs inactive (high), data enable off
    localparam vga_sync_t VGA_SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

    // Total pixels per line or lines per frame
    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int c_DEF_H_TOTAL = h_total(c_DEF_H_ACTIVE, c_DEF_H_FP, c_DEF_H_SYNC, c_DEF_H_BP);
    localparam int c_DEF_V_TOTAL = v_total(c_DEF_V_ACTIVE, c_DEF_V_FP, c_DEF_V_SYNC, c_DEF_V_BP);

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Purpose  : Timing bundle from the VGA timing generator to the renderer.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;

    logic                          pix_tick;
    logic [vga_pkg::COORD_W-1:0]   x;
    logic [vga_pkg::COORD_W-1:0]   y;
    logic                          active;
    logic                          frame_start;
    logic                          hsync;
    logic                          vsync;
    logic                          de;

    modport master (
        output pix_tick, x, y, active, frame_start, hsync, vsync, de
    );

    modport slave (
        input  pix_tick, x, y, active, frame_start, hsync, vsync, de
    );

endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Purpose  : DEPTH-stage, enable-gated delay of the sync/de triple so that
//            sync leaves the block aligned with the renderer's RGB.
// Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_en,
    input  wire vga_sync_t i_d,
    output vga_sync_t      o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No latency: raw decode passes straight through
            logic w_unused_bypass;
            assign w_unused_bypass = clk ^ rst ^ i_en;
            assign o_q             = i_d;
        end else begin : g_pipe
            vga_sync_t r_stage [DEPTH];

            // Shift one stage per pixel tick; reset blanks every stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= VGA_SYNC_IDLE;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel-tick divider, x/y scan counters, sync/active decode and
//            latency-matched hsync/vsync/de for the VGA output path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = c_DEF_CLK_DIV,
    parameter int H_ACTIVE = c_DEF_H_ACTIVE,
    parameter int H_FP     = c_DEF_H_FP,
    parameter int H_SYNC   = c_DEF_H_SYNC,
    parameter int H_BP     = c_DEF_H_BP,
    parameter int V_ACTIVE = c_DEF_V_ACTIVE,
    parameter int V_FP     = c_DEF_V_FP,
    parameter int V_SYNC   = c_DEF_V_SYNC,
    parameter int V_BP     = c_DEF_V_BP,
    parameter int PIPE_LAT = c_DEF_PIPE_LAT
) (
    input  wire logic           clk_100mhz,
    input  wire logic           rst,
    vga_timing_gen_if.master    o_vga
);

    localparam int c_H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] c_X_LAST   = COORD_W'(c_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_Y_LAST   = COORD_W'(c_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] c_H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] c_HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] c_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] c_VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] c_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    // Refuse to build timings that do not fit the 10-bit counters
    generate
        if (CLK_DIV < 1) begin : g_chk_clk_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (c_H_TOTAL > 1024) begin : g_chk_h_total
            $error("vga_timing_gen: H_TOTAL exceeds 10-bit range");
        end
        if (c_V_TOTAL > 1024) begin : g_chk_v_total
            $error("vga_timing_gen: V_TOTAL exceeds 10-bit range");
        end
    endgenerate

    logic [c_DIV_W-1:0] r_div;
    logic               r_run;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_pix_tick;
    logic               w_active;
    logic               w_hs_zone;
    logic               w_vs_zone;
    vga_sync_t          w_raw;
    vga_sync_t          w_dly;

    // Pixel-rate divider; r_run keeps the tick low while reset is applied,
    // which only matters when CLK_DIV = 1 and the divider is always "last"
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_div <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    assign w_pix_tick = r_run && (r_div == c_DIV_LAST);

    // Scan counters advance on the edge that ends a pix_tick cycle
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pix_tick) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    // Region decode from the current registered coordinates
    always_comb begin
        w_active  = (r_x < c_H_ACT) && (r_y < c_V_ACT);
        w_hs_zone = (r_x >= c_HS_BEG) && (r_x < c_HS_END);
        w_vs_zone = (r_y >= c_VS_BEG) && (r_y < c_VS_END);
        w_raw     = '{hsync: ~w_hs_zone, vsync: ~w_vs_zone, de: w_active};
    end

    vga_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk   (clk_100mhz),
        .rst   (rst),
        .i_en  (w_pix_tick),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    assign o_vga.pix_tick    = w_pix_tick;
    assign o_vga.x           = r_x;
    assign o_vga.y           = r_y;
    assign o_vga.active      = w_active;
    assign o_vga.frame_start = w_pix_tick && (r_x == '0) && (r_y == '0);
    assign o_vga.hsync       = w_dly.hsync;
    assign o_vga.vsync       = w_dly.vsync;
    assign o_vga.de          = w_dly.de;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen (default and reduced
//            timings, PIPE_LAT 0/2/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_VA = 480, D_VFP = 10, D_VS = 2;
    localparam int D_HT = 800, D_VT = 525;
    localparam int R_HA = 8, R_HFP = 2, R_HS = 3, R_VA = 4, R_VFP = 1, R_VS = 1;
    localparam int R_HT = 16, R_VT = 8;
    localparam logic [2:0] IDLE = 3'b110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_r0 ();
    vga_timing_gen_if if_r3 ();

    vga_timing_gen dut_d (.clk_100mhz(clk), .rst(rst), .o_vga(if_d));

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .PIPE_LAT(0)
    ) dut_r0 (.clk_100mhz(clk), .rst(rst), .o_vga(if_r0));

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .PIPE_LAT(3)
    ) dut_r3 (.clk_100mhz(clk), .rst(rst), .o_vga(if_r3));

    // Reference decode: {hsync_n, vsync_n, de} for a coordinate
    function automatic logic [2:0] raw_exp(input int x, input int y, input int ha, input int hfp,
                                           input int hs, input int va, input int vfp, input int vs);
        logic hs_n, vs_n, de;
        hs_n = !((x >= ha + hfp) && (x < ha + hfp + hs));
        vs_n = !((y >= va + vfp) && (y < va + vfp + vs));
        de   = (x < ha) && (y < va);
        return {hs_n, vs_n, de};
    endfunction

    // Wait (bounded) for the next negedge on which the chosen DUT ticks
    task automatic wait_tick(input int which, output bit ok);
        logic t;
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(negedge clk);
            case (which)
                0:       t = if_d.pix_tick;
                1:       t = if_r0.pix_tick;
                default: t = if_r3.pix_tick;
            endcase
            ok = (t === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [2:0] trip;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            trip = {if_d.hsync, if_d.vsync, if_d.de};
            if (c == 1) begin
                tests_run++;
                if ({if_d.x, if_d.y, if_d.pix_tick, if_d.active, if_d.frame_start, trip} !== {20'd0, 3'b010, IDLE}) begin
                    tests_failed++;
                    $display("FAIL reset_state got x=%0d y=%0d tick=%b act=%b fs=%b sync=%b want 0 0 0 1 0 110",
                             if_d.x, if_d.y, if_d.pix_tick, if_d.active, if_d.frame_start, trip);
                end
                rst = 1'b0;
            end
            tests_run++;
            if (if_d.pix_tick !== ((c % 4) == 0)) begin
                tests_failed++;
                $display("FAIL startup_tick cycle=%0d got %b want %b", c, if_d.pix_tick, (c % 4) == 0);
            end
            if (c <= 4) begin
                tests_run++;
                if ({if_d.x, if_d.y} !== 20'd0) begin
                    tests_failed++;
                    $display("FAIL startup_xy cycle=%0d got x=%0d y=%0d want 0 0", c, if_d.x, if_d.y);
                end
            end
            if (c >= 5 && c <= 8) begin
                tests_run++;
                if (if_d.x !== 10'd1) begin
                    tests_failed++;
                    $display("FAIL startup_x1 cycle=%0d got x=%0d want 1", c, if_d.x);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (if_d.frame_start !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL startup_frame_start got %b want 1", if_d.frame_start);
                end
            end
            if (c == 4 || c == 8) begin
                tests_run++;
                if (trip !== IDLE) begin
                    tests_failed++;
                    $display("FAIL startup_blank cycle=%0d got %b want %b", c, trip, IDLE);
                end
            end
            if (c == 12) begin
                tests_run++;
                if (trip !== 3'b111) begin
                    tests_failed++;
                    $display("FAIL startup_first_de got %b want 111", trip);
                end
            end
        end
    endtask

    task automatic test_line_timing();
        logic [2:0] q[$];
        logic [2:0] exp, got;
        int   ex = 0, ey = 0;
        int   fall[$];
        time  tf[$];
        logic prev_hs = 1'b1;
        int   hs_run = 0, hs_first = -1, de_run = 0, de_first = -1;
        bit   ok;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        q.push_back(IDLE); q.push_back(IDLE);
        for (int t = 0; t < 1700; t++) begin
            wait_tick(0, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL line_tick_timeout t=%0d got no tick want tick", t);
                return;
            end
            tests_run++;
            if ({if_d.x, if_d.y} !== {10'(ex), 10'(ey)}) begin
                tests_failed++;
                $display("FAIL line_xy t=%0d got %0d,%0d want %0d,%0d", t, if_d.x, if_d.y, ex, ey);
            end
            q.push_back(raw_exp(ex, ey, D_HA, D_HFP, D_HS, D_VA, D_VFP, D_VS));
            exp = q.pop_front();
            got = {if_d.hsync, if_d.vsync, if_d.de};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL line_sync t=%0d got %b want %b", t, got, exp);
            end
            tests_run++;
            if (if_d.active !== ((ex < D_HA) && (ey < D_VA))) begin
                tests_failed++;
                $display("FAIL line_active t=%0d got %b", t, if_d.active);
            end
            if (prev_hs === 1'b1 && if_d.hsync === 1'b0) begin
                fall.push_back(t);
                tf.push_back($time);
            end
            prev_hs = if_d.hsync;
            if (if_d.hsync === 1'b0) hs_run++;
            else begin
                if (hs_run > 0 && hs_first < 0) hs_first = hs_run;
                hs_run = 0;
            end
            if (if_d.de === 1'b1) de_run++;
            else begin
                if (de_run > 0 && de_first < 0) de_first = de_run;
                de_run = 0;
            end
            ex++;
            if (ex == D_HT) begin ex = 0; ey++; if (ey == D_VT) ey = 0; end
        end
        tests_run++;
        if (fall.size() < 2) begin
            tests_failed++;
            $display("FAIL line_hsync_edges got %0d falling edges want 2", fall.size());
        end else begin
            tests_run++;
            if (fall[0] != 658) begin
                tests_failed++;
                $display("FAIL line_hsync_start got tick %0d want 658", fall[0]);
            end
            tests_run++;
            if (fall[1] - fall[0] != 800 || tf[1] - tf[0] != 32000) begin
                tests_failed++;
                $display("FAIL line_period got %0d ticks %0t want 800 ticks 32000", fall[1] - fall[0], tf[1] - tf[0]);
            end
        end
        tests_run++;
        if (hs_first != 96) begin
            tests_failed++;
            $display("FAIL line_hsync_width got %0d want 96", hs_first);
        end
        tests_run++;
        if (de_first != 640) begin
            tests_failed++;
            $display("FAIL line_de_width got %0d want 640", de_first);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit found = 1'b0;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int t = 0; t < 1200 && !found; t++) begin
            wait_tick(0, ok);
            if (ok && if_d.x === 10'd300 && if_d.y === 10'd1) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL midrst_reach got no x=300 y=1 want reached");
            return;
        end
        tests_run++;
        if (if_d.de !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_de_before got %b want 1", if_d.de);
        end
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests_run++;
                if ({if_d.x, if_d.y, if_d.pix_tick, if_d.active, if_d.frame_start, if_d.hsync, if_d.vsync, if_d.de}
                    !== {20'd0, 3'b010, IDLE}) begin
                    tests_failed++;
                    $display("FAIL midrst_state got x=%0d y=%0d tick=%b act=%b sync=%b%b%b want 0 0 0 1 110",
                             if_d.x, if_d.y, if_d.pix_tick, if_d.active, if_d.hsync, if_d.vsync, if_d.de);
                end
                rst = 1'b0;
            end
            tests_run++;
            if (if_d.pix_tick !== (c == 4)) begin
                tests_failed++;
                $display("FAIL midrst_tick cycle=%0d got %b want %b", c, if_d.pix_tick, c == 4);
            end
        end
        tests_run++;
        if ({if_d.x, if_d.y, if_d.frame_start} !== {20'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL midrst_resume got x=%0d y=%0d fs=%b want 0 0 1", if_d.x, if_d.y, if_d.frame_start);
        end
        wait_tick(0, ok);
        tests_run++;
        if (!ok || if_d.x !== 10'd1) begin
            tests_failed++;
            $display("FAIL midrst_next got ok=%b x=%0d want 1 1", ok, if_d.x);
        end
    endtask

    task automatic test_reduced_wrap();
        logic [2:0] q[$];
        logic [2:0] exp, got;
        int   ex = 0, ey = 0, px, py;
        int   fs[$];
        int   vs_start = -1, vs_run = 0, vs_first = -1, de_cnt = 0;
        logic prev_vs = 1'b1;
        bit   ok;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (3) q.push_back(IDLE);
        for (int t = 0; t < 3 * 128 + 3; t++) begin
            wait_tick(2, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL red_tick_timeout t=%0d got no tick want tick", t);
                return;
            end
            tests_run++;
            if ({if_r3.x, if_r3.y, if_r3.frame_start} !== {10'(ex), 10'(ey), (ex == 0 && ey == 0)}) begin
                tests_failed++;
                $display("FAIL red_xy t=%0d got %0d,%0d fs=%b want %0d,%0d", t, if_r3.x, if_r3.y, if_r3.frame_start, ex, ey);
            end
            q.push_back(raw_exp(ex, ey, R_HA, R_HFP, R_HS, R_VA, R_VFP, R_VS));
            exp = q.pop_front();
            got = {if_r3.hsync, if_r3.vsync, if_r3.de};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL red_sync t=%0d got %b want %b", t, got, exp);
            end
            if (t > 0 && px == R_HT - 1) begin
                tests_run++;
                if (if_r3.x !== 10'd0 || if_r3.y !== 10'((py + 1) % R_VT)) begin
                    tests_failed++;
                    $display("FAIL red_x_wrap t=%0d got %0d,%0d want 0,%0d", t, if_r3.x, if_r3.y, (py + 1) % R_VT);
                end
                if (py == R_VT - 1) begin
                    tests_run++;
                    if (if_r3.y !== 10'd0) begin
                        tests_failed++;
                        $display("FAIL red_y_wrap t=%0d got %0d want 0", t, if_r3.y);
                    end
                end
            end
            if (if_r3.frame_start === 1'b1) fs.push_back(t);
            if (prev_vs === 1'b1 && if_r3.vsync === 1'b0 && vs_start < 0) vs_start = t;
            prev_vs = if_r3.vsync;
            if (if_r3.vsync === 1'b0) vs_run++;
            else begin
                if (vs_run > 0 && vs_first < 0) vs_first = vs_run;
                vs_run = 0;
            end
            if (t >= 3 && t < 131 && if_r3.de === 1'b1) de_cnt++;
            px = ex; py = ey;
            ex++;
            if (ex == R_HT) begin ex = 0; ey++; if (ey == R_VT) ey = 0; end
        end
        tests_run++;
        if (fs.size() != 4) begin
            tests_failed++;
            $display("FAIL red_frame_count got %0d want 4", fs.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                tests_run++;
                if (fs[i] - fs[i-1] != 128) begin
                    tests_failed++;
                    $display("FAIL red_frame_period got %0d want 128", fs[i] - fs[i-1]);
                end
            end
        end
        tests_run++;
        if (vs_start != 83 || vs_first != 16) begin
            tests_failed++;
            $display("FAIL red_vsync got start=%0d width=%0d want 83 16", vs_start, vs_first);
        end
        tests_run++;
        if (de_cnt != 32) begin
            tests_failed++;
            $display("FAIL red_de_count got %0d want 32", de_cnt);
        end
    endtask

    task automatic test_pipe_compare();
        logic [2:0] hist[$];
        logic [2:0] g0, g3, exp;
        int   ex = 0, ey = 0;
        bit   ok;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        repeat (3) hist.push_back(IDLE);
        for (int t = 0; t < 150; t++) begin
            wait_tick(1, ok);
            tests_run++;
            if (!ok || if_r3.pix_tick !== 1'b1) begin
                tests_failed++;
                $display("FAIL pipe_tick t=%0d got ok=%b r3=%b want 1 1", t, ok, if_r3.pix_tick);
                return;
            end
            g0  = {if_r0.hsync, if_r0.vsync, if_r0.de};
            g3  = {if_r3.hsync, if_r3.vsync, if_r3.de};
            exp = raw_exp(ex, ey, R_HA, R_HFP, R_HS, R_VA, R_VFP, R_VS);
            tests_run++;
            if (g0 !== exp) begin
                tests_failed++;
                $display("FAIL pipe0_raw t=%0d got %b want %b", t, g0, exp);
            end
            hist.push_back(g0);
            exp = hist.pop_front();
            tests_run++;
            if (g3 !== exp) begin
                tests_failed++;
                $display("FAIL pipe3_shift t=%0d got %b want %b", t, g3, exp);
            end
            ex++;
            if (ex == R_HT) begin ex = 0; ey++; if (ey == R_VT) ey = 0; end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_mid_reset();
        test_reduced_wrap();
        test_pipe_compare();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing front end of the VGA path. Divides the 100 MHz system clock into a pixel-tick enable and scans 640x480@60 Hz counters.
- Drives x/y coordinates to the pixel renderer.
- Emits hsync/vsync/de delayed by the renderer's pipeline latency, so sync and RGB leave vga_top aligned.
- Sits directly upstream of the renderer and the RGB output registers inside vga_top.

Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- PIPE_LAT, 2: renderer latency in pixel ticks. Sync/de outputs are delayed by this amount. 0 is legal.

Ports:
- clk_100mhz  in   1   system clock.
- rst         in   1   synchronous, active-high reset.
- pix_tick    out  1   one-clk pulse marking the last clk of each pixel period.
- x           out  10  current horizontal count, 0..H_TOTAL-1.
- y           out  10  current vertical count, 0..V_TOTAL-1.
- active      out  1   undelayed visible-region flag for the current x/y.
- frame_start out  1   pulse when pix_tick=1 and x=0, y=0.
- hsync       out  1   active-low horizontal sync, delayed PIPE_LAT ticks.
- vsync       out  1   active-low vertical sync, delayed PIPE_LAT ticks.
- de          out  1   data enable (active delayed PIPE_LAT ticks).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Reset (sampled on clk_100mhz rising edge):
  - div = 0, x = 0, y = 0.
  - pix_tick = 0, frame_start = 0, active = 1 (x=0, y=0 is visible).
  - hsync = 1, vsync = 1, de = 0.
  - Every delay-line stage is loaded with the inactive value (hsync=1, vsync=1, de=0).
  - Reset mid-frame takes effect on the next edge. No partial line completes.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1), decoded from registers. It is high exactly 1 clk in every CLK_DIV.
  - First pix_tick after reset deassert occurs in clk cycle CLK_DIV (the 4th cycle).
- Counters (advance only on the edge ending a pix_tick cycle):
  - x increments; at x == H_TOTAL-1, x wraps to 0 and y increments.
  - At y == V_TOTAL-1 together with the x wrap, y wraps to 0.
  - Each x/y value is stable for exactly CLK_DIV clks. The renderer samples on pix_tick.
- Raw decode from the current x/y:
  - active = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hsync_raw = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync_raw = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491. Decoded on line count only.
  - frame_start = pix_tick && x == 0 && y == 0.
- Delay line:
  - The {hsync_raw, vsync_raw, active} triple passes through PIPE_LAT registers that shift only when pix_tick = 1.
  - PIPE_LAT = 0: outputs equal the raw decode, combinational from the x/y registers.
  - After reset, the first PIPE_LAT pixels out are blanked (de = 0, syncs high).
- Frame period: 800 * 525 * 4 = 1,680,000 clks (16.8 ms).
- Widths:
  - All compares are unsigned, 10-bit.
  - Elaboration fails if H_TOTAL > 1024 or V_TOTAL > 1024, or if CLK_DIV < 1.
  - CLK_DIV = 1 yields pix_tick tied high after reset.

Decomposition:
- vga_pkg holds:
  - default timing localparams;
  - H_TOTAL/V_TOTAL functions of the parameters;
  - COORD_W = 10;
  - packed struct vga_sync_t {hsync, vsync, de};
  - VGA_SYNC_IDLE constant = {1, 1, 0}.
- Sub-module vga_delay_line:
  - parameter DEPTH, payload vga_sync_t, enable pix_tick;
  - synchronous reset to VGA_SYNC_IDLE;
  - a generate bypass when DEPTH = 0.
- Counters and decode stay in vga_timing_gen.

Test Plan:
1. Reset/start-up: rst high 10 clks, then low. Required:
   - pix_tick is first high in the 4th clk after deassert, then every 4 clks;
   - x = y = 0 for the first 4 clks;
   - hsync = vsync = 1 and de = 0 for the first 2 ticks (PIPE_LAT = 2).
2. Line timing (default params): measure over one line. Required:
   - 800 ticks (3200 clks) between hsync falling edges;
   - hsync low for 96 ticks;
   - falling edge 2 ticks after raw x = 656;
   - de high for 640 consecutive ticks per visible line.
3. Frame timing (default params, full-frame run): required:
   - frame_start every 420,000 ticks;
   - vsync low for exactly 1,600 ticks, beginning 2 ticks after y = 490, x = 0;
   - de-high tick count per frame = 307,200.
4. Reduced-timing wrap (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, CLK_DIV=4): for 3 frames, check:
   - x wraps 15 -> 0 with y increment;
   - y wraps 7 -> 0;
   - frame_start every 128 ticks (512 clks).
5. Reset mid-frame at x = 300, y = 200 (de = 1): assert rst for 1 clk. Required next edge:
   - x = y = 0, div = 0, pix_tick = 0, active = 1, de = 0, syncs high;
   - normal scan resumes with the first tick 4 clks after release.
6. PIPE_LAT = 0 versus PIPE_LAT = 3 (reduced params): hsync/vsync/de of the PIPE_LAT = 3 build equal the PIPE_LAT = 0 build shifted by exactly 3 ticks (12 clks).
